// File: rtl/board_scan_scheduler.sv
// Walks all Sudoku cells in row-major order, runs the shared digit predictor on every
// inked cell and collects the recognised digits into a packed board register.
module board_scan_scheduler #(
    parameter int NUM_CELLS     = 81,
    parameter int IDX_W         = 7,
    parameter int SETTLE_CYCLES = 2,
    parameter int GAP_CYCLES    = 3,
    parameter int TIMEOUT       = 4096
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_scan,
    input  logic                   abort,
    input  logic [NUM_CELLS-1:0]   cell_mask,
    output logic [IDX_W-1:0]       cell_idx,
    output logic                   pred_start,
    input  logic                   pred_finish,
    input  logic [3:0]             pred_number,
    output logic [4*NUM_CELLS-1:0] board,
    output logic                   busy,
    output logic                   done,
    output logic                   aborted,
    output logic [IDX_W-1:0]       err_count
);

    // One shared counter serves the settle, wait and gap phases; size it for the longest.
    localparam int CNT_MAX_A = (SETTLE_CYCLES > GAP_CYCLES) ? SETTLE_CYCLES - 1 : GAP_CYCLES - 1;
    localparam int CNT_MAX   = (TIMEOUT - 1 > CNT_MAX_A) ? TIMEOUT - 1 : CNT_MAX_A;
    localparam int CNT_W     = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CELLS - 1);
    localparam logic [IDX_W-1:0] ERR_MAX  = '1;
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD    = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST   = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SELECT, S_SETTLE, S_START, S_WAIT, S_GAP, S_NEXT, S_DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic             cnt_zero;
    logic             cell_inked;
    logic             wait_expired;
    logic             abort_hit;
    logic             slot_we;
    logic [3:0]       slot_val;
    logic             err_inc;

    assign cnt_zero     = (cnt == '0);
    assign cell_inked   = cell_mask[cell_idx];
    assign wait_expired = (state == S_WAIT) && (cnt == WAIT_LAST);
    assign abort_hit    = abort && (state != S_IDLE) && (state != S_DONE);

    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:   if (start_scan) state_next = S_SELECT;
            S_SELECT: state_next = cell_inked ? S_SETTLE : S_NEXT;
            S_SETTLE: if (cnt_zero) state_next = S_START;
            S_START:  state_next = S_WAIT;
            S_WAIT:   if (pred_finish || wait_expired) state_next = S_GAP;
            S_GAP:    if (cnt_zero) state_next = S_NEXT;
            S_NEXT:   state_next = (cell_idx == LAST_IDX) ? S_DONE : S_SELECT;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
        if (abort_hit) state_next = S_IDLE;
    end

    always_comb begin
        pred_start = (state == S_START);
        done       = (state == S_DONE);
        busy       = (state != S_IDLE);
    end

    // Decide what, if anything, lands in the current cell's slot this cycle.
    always_comb begin
        slot_we  = 1'b0;
        slot_val = 4'd0;
        err_inc  = 1'b0;
        if (!abort_hit) begin
            if (state == S_SELECT && !cell_inked) begin
                slot_we = 1'b1;
            end else if (state == S_WAIT && pred_finish) begin
                slot_we = 1'b1;
                if (pred_number <= 4'd9) slot_val = pred_number;
                else                     err_inc  = 1'b1;
            end else if (wait_expired) begin
                slot_we = 1'b1;
                err_inc = 1'b1;
            end
        end
    end

    // NOTE: board is a plain register bank, so it is cleared by reset along with the rest.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cell_idx  <= '0;
            board     <= '0;
            err_count <= '0;
            cnt       <= '0;
            aborted   <= 1'b0;
        end else begin
            aborted <= abort_hit;

            if (state == S_IDLE && start_scan) begin
                cell_idx  <= '0;
                board     <= '0;
                err_count <= '0;
            end

            if (state == S_NEXT && !abort_hit && cell_idx != LAST_IDX) begin
                cell_idx <= cell_idx + 1'b1;
            end

            if (slot_we) begin
                for (int i = 0; i < NUM_CELLS; i++) begin
                    if (cell_idx == IDX_W'(i)) board[4*i +: 4] <= slot_val;
                end
            end

            if (err_inc && err_count != ERR_MAX) begin
                err_count <= err_count + 1'b1;
            end

            unique case (state)
                S_SELECT: cnt <= SETTLE_LOAD;
                S_SETTLE: if (!cnt_zero) cnt <= cnt - 1'b1;
                S_START:  cnt <= '0;
                S_WAIT:   cnt <= (pred_finish || wait_expired) ? GAP_LOAD : cnt + 1'b1;
                S_GAP:    if (!cnt_zero) cnt <= cnt - 1'b1;
                default:  cnt <= cnt;
            endcase
        end
    end

endmodule
